btn_conditioner: RTL and testbench

BTN_CONDITIONER -- requirements
Module: btn_conditioner

---
 rtl/btn_conditioner.sv | 195 +++++++++++++++++++
 tb/tb_btn_conditioner.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/btn_conditioner.sv
// ---------------------------------------------------------------------------
// btn_conditioner
//
// Purpose:
//   Conditions five raw push-buttons. Each channel is synchronised, debounced
//   by a four-state FSM and produces a debounced level plus a one-cycle press
//   strobe. The five channels are fully independent of each other.
//
// Optional feature (macro BTN_AUTO_REPEAT_EN):
//   When defined, a held button also strobes BTN_PULSE after REPEAT_DELAY_CYC
//   cycles and then every REPEAT_RATE_CYC cycles. The repeat counter is frozen
//   while a release is being debounced. When undefined, the repeat logic is
//   absent and every accepted press gives exactly one strobe.
//
// Parameters:
//   DEBOUNCE_CYC     - stable-input cycles needed to accept a press or release
//   REPEAT_DELAY_CYC - cycles from an accepted press to the first repeat strobe
//   REPEAT_RATE_CYC  - cycles between later repeat strobes
//
// Ports:
//   CLK        in   system clock (100 kHz)
//   RESET      in   asynchronous, active-high reset
//   BTN_RAW    in   [4:0] raw active-high buttons (A,B,C,D,E = bit0..bit4)
//   BTN_LEVEL  out  [4:0] debounced level (1 in HELD / RELEASE_WAIT)
//   BTN_PULSE  out  [4:0] one-cycle strobe per accepted press / repeat
// ---------------------------------------------------------------------------
module btn_conditioner #(
    parameter int unsigned DEBOUNCE_CYC     = 2000,
    parameter int unsigned REPEAT_DELAY_CYC = 50000,
    parameter int unsigned REPEAT_RATE_CYC  = 10000
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic [4:0] BTN_RAW,
    output logic [4:0] BTN_LEVEL,
    output logic [4:0] BTN_PULSE
);

    localparam int unsigned NCH = 5;
    localparam logic [16:0] DB_LAST = 17'(DEBOUNCE_CYC - 1);

    // Counters are 17 bits wide; the repeat thresholds must also be at least
    // 2 so that a strobe can never follow another on the next cycle.
    if (DEBOUNCE_CYC < 1 || DEBOUNCE_CYC > 131072 ||
        REPEAT_DELAY_CYC < 2 || REPEAT_DELAY_CYC > 131072 ||
        REPEAT_RATE_CYC < 2 || REPEAT_RATE_CYC > 131072) begin : g_param_check
        $error("btn_conditioner: parameter out of range");
    end

    typedef enum logic [1:0] {
        IDLE,
        PRESS_WAIT,
        HELD,
        RELEASE_WAIT
    } state_t;

    function automatic logic [16:0] sat_inc(input logic [16:0] v);
        return (v == '1) ? v : v + 17'd1;
    endfunction

    logic [4:0]  sync1_q;
    logic [4:0]  sync2_q;
    state_t      state_q [NCH];
    state_t      state_d [NCH];
    logic [16:0] dcnt_q  [NCH];
    logic [16:0] dcnt_d  [NCH];
    logic [4:0]  pulse_d;

`ifdef BTN_AUTO_REPEAT_EN
    localparam logic [16:0] DELAY_LAST = 17'(REPEAT_DELAY_CYC - 1);
    localparam logic [16:0] RATE_LAST  = 17'(REPEAT_RATE_CYC - 1);

    logic [16:0] rcnt_q   [NCH];
    logic [16:0] rcnt_d   [NCH];
    // Set after the first repeat strobe: later strobes use the rate threshold.
    logic [4:0]  rphase_q;
    logic [4:0]  rphase_d;
`endif

    // Next-state / output logic for all channels.
    always_comb begin
        pulse_d = '0;
`ifdef BTN_AUTO_REPEAT_EN
        rphase_d = rphase_q;
`endif
        for (int unsigned i = 0; i < NCH; i++) begin
            state_d[i] = state_q[i];
            dcnt_d[i]  = dcnt_q[i];
`ifdef BTN_AUTO_REPEAT_EN
            rcnt_d[i]  = rcnt_q[i];
`endif
            unique case (state_q[i])
                IDLE: begin
                    dcnt_d[i] = '0;
                    if (sync2_q[i]) begin
                        state_d[i] = PRESS_WAIT;
                    end
                end
                PRESS_WAIT: begin
                    if (!sync2_q[i]) begin
                        state_d[i] = IDLE;
                        dcnt_d[i]  = '0;
                    end else if (dcnt_q[i] == DB_LAST) begin
                        state_d[i] = HELD;
                        dcnt_d[i]  = '0;
                        pulse_d[i] = 1'b1;
`ifdef BTN_AUTO_REPEAT_EN
                        rcnt_d[i]   = '0;
                        rphase_d[i] = 1'b0;
`endif
                    end else begin
                        dcnt_d[i] = sat_inc(dcnt_q[i]);
                    end
                end
                HELD: begin
`ifdef BTN_AUTO_REPEAT_EN
                    // Counts on every HELD cycle, including the one that
                    // leaves for RELEASE_WAIT, so a glitch of N cycles
                    // delays the schedule by exactly N cycles.
                    if (rcnt_q[i] == (rphase_q[i] ? RATE_LAST : DELAY_LAST)) begin
                        pulse_d[i]  = 1'b1;
                        rcnt_d[i]   = '0;
                        rphase_d[i] = 1'b1;
                    end else begin
                        rcnt_d[i] = sat_inc(rcnt_q[i]);
                    end
`endif
                    if (!sync2_q[i]) begin
                        state_d[i] = RELEASE_WAIT;
                        dcnt_d[i]  = '0;
                    end
                end
                RELEASE_WAIT: begin
                    if (sync2_q[i]) begin
                        state_d[i] = HELD;
                        dcnt_d[i]  = '0;
                    end else if (dcnt_q[i] == DB_LAST) begin
                        state_d[i] = IDLE;
                        dcnt_d[i]  = '0;
`ifdef BTN_AUTO_REPEAT_EN
                        rcnt_d[i]   = '0;
                        rphase_d[i] = 1'b0;
`endif
                    end else begin
                        dcnt_d[i] = sat_inc(dcnt_q[i]);
                    end
                end
                default: begin
                    state_d[i] = IDLE;
                    dcnt_d[i]  = '0;
                end
            endcase
        end
    end

    always_comb begin
        BTN_LEVEL = '0;
        for (int unsigned i = 0; i < NCH; i++) begin
            BTN_LEVEL[i] = (state_q[i] == HELD) || (state_q[i] == RELEASE_WAIT);
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            BTN_PULSE <= '0;
            for (int unsigned i = 0; i < NCH; i++) begin
                state_q[i] <= IDLE;
                dcnt_q[i]  <= '0;
`ifdef BTN_AUTO_REPEAT_EN
                rcnt_q[i]  <= '0;
`endif
            end
`ifdef BTN_AUTO_REPEAT_EN
            rphase_q <= '0;
`endif
        end else begin
            sync1_q   <= BTN_RAW;
            sync2_q   <= sync1_q;
            BTN_PULSE <= pulse_d;
            for (int unsigned i = 0; i < NCH; i++) begin
                state_q[i] <= state_d[i];
                dcnt_q[i]  <= dcnt_d[i];
`ifdef BTN_AUTO_REPEAT_EN
                rcnt_q[i]  <= rcnt_d[i];
`endif
            end
`ifdef BTN_AUTO_REPEAT_EN
            rphase_q <= rphase_d;
`endif
        end
    end

endmodule

// File: tb/tb_btn_conditioner.sv
// ---------------------------------------------------------------------------
// tb_btn_conditioner
//
// Directed, table-driven bench for btn_conditioner with DEBOUNCE_CYC=4,
// REPEAT_DELAY_CYC=20, REPEAT_RATE_CYC=8. Edge k is the k-th rising clock
// edge of a sequence; edge 0 is the first edge that samples the new input.
// Expected pulse schedules follow BTN_AUTO_REPEAT_EN.
// ---------------------------------------------------------------------------
module tb_btn_conditioner;

    logic       CLK = 1'b0;
    logic       RESET;
    logic [4:0] BTN_RAW;
    logic [4:0] BTN_LEVEL;
    logic [4:0] BTN_PULSE;

    int tests  = 0;
    int failed = 0;

    typedef struct {
        logic [4:0] raw;
        logic [4:0] lvl;
        logic [4:0] pls;
    } vec_t;

    vec_t vecs[$];

    btn_conditioner #(
        .DEBOUNCE_CYC    (4),
        .REPEAT_DELAY_CYC(20),
        .REPEAT_RATE_CYC (8)
    ) dut (
        .CLK      (CLK),
        .RESET    (RESET),
        .BTN_RAW  (BTN_RAW),
        .BTN_LEVEL(BTN_LEVEL),
        .BTN_PULSE(BTN_PULSE)
    );

    always #5 CLK = ~CLK;

    // Drive on the falling edge, sample 1 time unit after the rising edge.
    task automatic tick(input logic [4:0] raw, input logic rst);
        @(negedge CLK);
        BTN_RAW = raw;
        RESET   = rst;
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string name, input int idx,
                       input logic [4:0] lvl, input logic [4:0] pls);
        tests++;
        if (BTN_LEVEL !== lvl || BTN_PULSE !== pls) begin
            failed++;
            $display("FAIL %s[%0d]: level=%b pulse=%b, required level=%b pulse=%b",
                     name, idx, BTN_LEVEL, BTN_PULSE, lvl, pls);
        end
    endtask

    task automatic add(input logic [4:0] raw, input logic [4:0] lvl, input logic [4:0] pls);
        vecs.push_back('{raw: raw, lvl: lvl, pls: pls});
    endtask

    function automatic logic [4:0] sel(input bit c, input logic [4:0] v);
        return c ? v : 5'b00000;
    endfunction

    initial begin
        // Vector table; each block starts and ends with all channels idle.
        // Clean press on A, 10 samples high.
        for (int k = 0; k < 20; k++)
            add(sel(k < 10, 5'b00001), sel(k >= 6 && k < 16, 5'b00001), sel(k == 6, 5'b00001));
        // Bouncing B: 1,0,1,0 for 12 samples, then low.
        for (int k = 0; k < 16; k++)
            add(sel(k < 12 && (k % 2) == 0, 5'b00010), 5'b00000, 5'b00000);
        // A high for 4 samples: one short of acceptance.
        for (int k = 0; k < 10; k++)
            add(sel(k < 4, 5'b00001), 5'b00000, 5'b00000);
        // A high for 5 samples: shortest accepted press.
        for (int k = 0; k < 14; k++)
            add(sel(k < 5, 5'b00001), sel(k >= 6 && k < 11, 5'b00001), sel(k == 6, 5'b00001));
        // D and E pressed together for 8 samples.
        for (int k = 0; k < 18; k++)
            add(sel(k < 8, 5'b11000), sel(k >= 6 && k < 14, 5'b11000), sel(k == 6, 5'b11000));

        // Reset state with every button pressed.
        BTN_RAW = 5'b11111;
        RESET   = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick(5'b11111, 1'b1);
            chk("reset_hold", k, 5'b00000, 5'b00000);
        end

        // Buttons held through reset release count as a fresh press.
        for (int j = 0; j < 18; j++) begin
            tick(sel(j < 8, 5'b11111), 1'b0);
            chk("held_thru_reset", j, sel(j >= 6 && j < 14, 5'b11111), sel(j == 6, 5'b11111));
        end

        for (int i = 0; i < vecs.size(); i++) begin
            tick(vecs[i].raw, 1'b0);
            chk("vec", i, vecs[i].lvl, vecs[i].pls);
        end

        // C held 46 samples: first strobe, then auto-repeat schedule.
        for (int k = 0; k < 57; k++) begin
            bit p;
`ifdef BTN_AUTO_REPEAT_EN
            p = (k == 6 || k == 26 || k == 34 || k == 42);
`else
            p = (k == 6);
`endif
            tick(sel(k < 46, 5'b00100), 1'b0);
            chk("repeat_c", k, sel(k >= 6 && k < 52, 5'b00100), sel(p, 5'b00100));
        end

        // C held with a 2-sample release glitch at samples 10,11.
        for (int k = 0; k < 57; k++) begin
            bit p;
`ifdef BTN_AUTO_REPEAT_EN
            p = (k == 6 || k == 28 || k == 36 || k == 44);
`else
            p = (k == 6);
`endif
            tick(sel(k < 46 && k != 10 && k != 11, 5'b00100), 1'b0);
            chk("glitch_c", k, sel(k >= 6 && k < 52, 5'b00100), sel(p, 5'b00100));
        end

        // Reset during the debounce of a press on A.
        for (int k = 0; k < 4; k++) begin
            tick(5'b00001, 1'b0);
            chk("rst_debounce", k, 5'b00000, 5'b00000);
        end
        #1 RESET = 1'b1;
        #1 chk("rst_debounce_async", 0, 5'b00000, 5'b00000);
        for (int k = 0; k < 2; k++) begin
            tick(5'b00001, 1'b1);
            chk("rst_debounce_hold", k, 5'b00000, 5'b00000);
        end
        for (int j = 0; j < 19; j++) begin
            tick(sel(j < 10, 5'b00001), 1'b0);
            chk("post_reset", j, sel(j >= 6 && j < 16, 5'b00001), sel(j == 6, 5'b00001));
        end

        // Reset in the cycle the press strobe is high.
        for (int k = 0; k < 7; k++) begin
            tick(5'b00001, 1'b0);
            chk("pre_reset", k, sel(k == 6, 5'b00001), sel(k == 6, 5'b00001));
        end
        #1 RESET = 1'b1;
        #1 chk("rst_on_pulse_async", 0, 5'b00000, 5'b00000);
        for (int k = 0; k < 2; k++) begin
            tick(5'b00000, 1'b1);
            chk("rst_on_pulse_hold", k, 5'b00000, 5'b00000);
        end
        for (int j = 0; j < 10; j++) begin
            tick(5'b00000, 1'b0);
            chk("no_residual", j, 5'b00000, 5'b00000);
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
